// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch controller
package fetch_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Instruction fetches are word-granular; low address bits are discarded.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/adder32.sv
// rtl/adder32.sv - 32-bit modulo adder
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);
  // Carry-out is dropped so the sum wraps modulo 2^32.
  assign sum = a + b;
endmodule

// File: rtl/mux2.sv
// rtl/mux2.sv - parameterised two-input multiplexer
module mux2 #(
  parameter int W = 32
) (
  input  logic         sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = sel ? b : a;
endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - single-outstanding instruction fetch FSM with redirect and response drop
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_data,
  output logic        misalign_err
);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_inc;
  logic [31:0] pc_next;
  logic [31:0] target_al;
  logic        drop;
  logic        pc_load;

  adder32 u_pc_add (
    .a   (pc),
    .b   (PC_INC),
    .sum (pc_inc)
  );

  assign target_al = align_word(redirect_target);

  mux2 #(.W(32)) u_pc_mux (
    .sel (redirect),
    .a   (pc_inc),
    .b   (target_al),
    .y   (pc_next)
  );

  // Redirect reloads PC in any state; sequential advance only on decode acceptance.
  assign pc_load   = redirect || (state == S_HOLD && instr_ready);
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      pc           <= RESET_PC;
      imem_req     <= 1'b0;
      instr_valid  <= 1'b0;
      instr_pc     <= 32'd0;
      instr_data   <= 32'd0;
      misalign_err <= 1'b0;
      drop         <= 1'b0;
    end else begin
      misalign_err <= redirect && (redirect_target[1:0] != 2'b00);
      if (pc_load) pc <= pc_next;

      case (state)
        S_IDLE: begin
          state    <= S_REQ;
          imem_req <= 1'b1;
        end
        S_REQ: begin
          if (imem_gnt) begin
            state    <= S_WAIT;
            imem_req <= 1'b0;
            drop     <= redirect;
          end
        end
        S_WAIT: begin
          // A redirected request stays in WAIT until its response returns,
          // so only one request is ever in flight.
          if (imem_rvalid) begin
            drop <= 1'b0;
            if (drop || redirect) begin
              state    <= S_REQ;
              imem_req <= 1'b1;
            end else begin
              state       <= S_HOLD;
              instr_valid <= 1'b1;
              instr_pc    <= pc;
              instr_data  <= imem_rdata;
            end
          end else if (redirect) begin
            drop <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect || instr_ready) begin
            state       <= S_REQ;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
